turn_timer: RTL and testbench

Per-turn countdown for the Connect-4 game. It watches the game controller's state code and restarts a seconds countdown each time a new `PLAYER_TURN` begins. On expiry it emits a one-cycle `times_up` pulse, which the controller edge-detects to force a random move. It also drives BCD seconds digits and a low-time warning for the seven-segment/VGA display path.

---
 rtl/connect4_pkg.sv | 46 ++++
 rtl/tick_prescaler.sv | 40 ++++
 rtl/turn_timer.sv | 150 +++++++++++++++
 tb/tb_turn_timer.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/connect4_pkg.sv
// Shared Connect-4 definitions: controller state codes, turn-timer constants,
// and the binary-to-BCD helper used for the seconds display.
package connect4_pkg;

    // Game controller state codes, shared by the controller and its helpers.
    typedef enum logic [2:0] {
        StIdle         = 3'd0,
        StPlayerTurn   = 3'd1,
        StMakeMove     = 3'd2,
        StCheckWin     = 3'd3,
        StSwitchPlayer = 3'd4,
        StGameOver     = 3'd5
    } state_t;

    localparam int unsigned StateW = 3;

    // Turn timer defaults and display widths.
    localparam int unsigned TurnSecondsDefault = 10;
    localparam int unsigned SecW               = 7;
    localparam int unsigned BcdW               = 4;

    // Internal turn timer FSM states.
    typedef enum logic [1:0] {
        TIdle,
        TRun,
        TExpired,
        THalt
    } timer_state_t;

    // Two-digit BCD of a 0..99 binary value, packed as {tens, ones}.
    // Divide-by-10 by descending compare; values above 99 are not meaningful.
    function automatic logic [2*BcdW-1:0] bin_to_bcd(input logic [SecW-1:0] bin);
        logic [BcdW-1:0] tens;
        logic [SecW-1:0] rem;
        tens = '0;
        rem  = bin;
        for (int i = 9; i >= 1; i--) begin
            if (tens == '0 && bin >= SecW'(10 * i)) begin
                tens = BcdW'(i);
                rem  = bin - SecW'(10 * i);
            end
        end
        return {tens, BcdW'(rem)};
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider that emits a one-cycle tick every CLK_HZ enabled cycles.
// The tick is combinational on the last count so the consumer acts on the
// same edge that wraps the counter.
module tick_prescaler #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned    CntW   = $clog2(CLK_HZ);
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_HZ - 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    // Next count: clear dominates, otherwise count 0..CLK_HZ-1 while enabled.
    always_comb begin
        tick  = enable && !clear && (cnt_q == CntMax);
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/turn_timer.sv
// Per-turn countdown for Connect-4. Restarts on each new PLAYER_TURN, pulses
// times_up on expiry, and drives BCD digits plus a low-time warning.
module turn_timer
    import connect4_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned TURN_SECONDS = TurnSecondsDefault,
    parameter int unsigned WARN_SECONDS = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [StateW-1:0] state,
    input  logic              pause,
    output logic              times_up,
    output logic [SecW-1:0]   seconds_left,
    output logic [BcdW-1:0]   sec_tens,
    output logic [BcdW-1:0]   sec_ones,
    output logic              warn,
    output logic              running
);

    localparam logic [SecW-1:0]     TurnSec = SecW'(TURN_SECONDS);
    localparam logic [2*BcdW-1:0]   TurnBcd = bin_to_bcd(TurnSec);

    timer_state_t    fsm_q;
    state_t          prev_state_q;
    logic [SecW-1:0] seconds_left_q;
    logic [BcdW-1:0] sec_tens_q;
    logic [BcdW-1:0] sec_ones_q;
    logic            times_up_q;
    logic            warn_q;
    logic            running_q;

    state_t ctrl_state;
    logic   in_turn;
    logic   game_over;
    logic   start_evt;
    logic   presc_clear;
    logic   presc_en;
    logic   tick;

    // Warning level for a given remaining-seconds value while running.
    function automatic logic warn_of(input logic [SecW-1:0] s);
        return (s != '0) && (s <= SecW'(WARN_SECONDS));
    endfunction

    // Decode the controller state and derive prescaler control.
    always_comb begin
        ctrl_state = state_t'(state);
        in_turn    = (ctrl_state == StPlayerTurn);
        game_over  = (ctrl_state == StGameOver);
        start_evt  = in_turn && (prev_state_q != StPlayerTurn);
        // Keep the prescaler at zero unless it is counting a live turn, so a
        // load or reload always starts a full second.
        presc_clear = (fsm_q != TRun) || !in_turn;
        presc_en    = (fsm_q == TRun) && !pause;
    end

    tick_prescaler #(
        .CLK_HZ (CLK_HZ)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (presc_clear),
        .enable (presc_en),
        .tick   (tick)
    );

    // Timer FSM with registered countdown, pulse, status and BCD outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fsm_q          <= TIdle;
            prev_state_q   <= StIdle;
            seconds_left_q <= TurnSec;
            sec_tens_q     <= TurnBcd[2*BcdW-1:BcdW];
            sec_ones_q     <= TurnBcd[BcdW-1:0];
            times_up_q     <= 1'b0;
            warn_q         <= 1'b0;
            running_q      <= 1'b0;
        end else begin
            prev_state_q <= ctrl_state;
            times_up_q   <= 1'b0;
            // Display digits trail seconds_left by one cycle.
            {sec_tens_q, sec_ones_q} <= bin_to_bcd(seconds_left_q);

            if (game_over) begin
                // Game over freezes the timer until reset, from any state.
                fsm_q     <= THalt;
                running_q <= 1'b0;
                warn_q    <= 1'b0;
            end else begin
                unique case (fsm_q)
                    TIdle: begin
                        if (start_evt) begin
                            fsm_q          <= TRun;
                            seconds_left_q <= TurnSec;
                            running_q      <= 1'b1;
                            warn_q         <= warn_of(TurnSec);
                        end
                    end
                    TRun: begin
                        if (!in_turn) begin
                            // Move made (or turn abandoned): leaving beats an
                            // expiring tick; seconds_left holds for display.
                            fsm_q     <= TIdle;
                            running_q <= 1'b0;
                            warn_q    <= 1'b0;
                        end else if (tick) begin
                            if (seconds_left_q > SecW'(1)) begin
                                seconds_left_q <= seconds_left_q - 1'b1;
                                warn_q         <= warn_of(seconds_left_q - 1'b1);
                            end else begin
                                seconds_left_q <= '0;
                                times_up_q     <= 1'b1;
                                fsm_q          <= TExpired;
                                running_q      <= 1'b0;
                                warn_q         <= 1'b0;
                            end
                        end
                    end
                    TExpired: begin
                        if (in_turn) begin
                            // Controller stayed in its turn (full column): go again.
                            fsm_q          <= TRun;
                            seconds_left_q <= TurnSec;
                            running_q      <= 1'b1;
                            warn_q         <= warn_of(TurnSec);
                        end else begin
                            fsm_q     <= TIdle;
                            running_q <= 1'b0;
                            warn_q    <= 1'b0;
                        end
                    end
                    THalt: begin
                        running_q <= 1'b0;
                        warn_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign times_up     = times_up_q;
    assign seconds_left = seconds_left_q;
    assign sec_tens     = sec_tens_q;
    assign sec_ones     = sec_ones_q;
    assign warn         = warn_q;
    assign running      = running_q;

endmodule

// File: tb/tb_turn_timer.sv
// Self-checking bench for turn_timer: directed scenarios plus a randomized run,
// all compared against a cycle-budget reference model of the turn countdown.
module tb_turn_timer;

    localparam int ClkHz   = 4;
    localparam int TurnS   = 3;
    localparam int WarnS   = 1;
    localparam int TurnCyc = TurnS * ClkHz;

    localparam int MIdle = 0;
    localparam int MRun  = 1;
    localparam int MExp  = 2;
    localparam int MHalt = 3;

    logic       clk;
    logic       reset;
    logic [2:0] state;
    logic       pause;
    logic       times_up;
    logic [6:0] seconds_left;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       warn;
    logic       running;
    logic [17:0] obs;

    int errors;
    int checks;

    // Reference model: remaining unpaused cycles of the turn; seconds shown
    // are that budget rounded up to whole seconds.
    int m_mode;
    int m_prev;
    int m_remain;
    int m_sec;
    int m_tens;
    int m_ones;
    bit m_tu;
    bit m_warn;
    bit m_run;

    turn_timer #(
        .CLK_HZ       (ClkHz),
        .TURN_SECONDS (TurnS),
        .WARN_SECONDS (WarnS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .state        (state),
        .pause        (pause),
        .times_up     (times_up),
        .seconds_left (seconds_left),
        .sec_tens     (sec_tens),
        .sec_ones     (sec_ones),
        .warn         (warn),
        .running      (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {times_up, seconds_left, sec_tens, sec_ones, warn, running};

    function automatic void model_step(input int st, input bit pa, input bit rs);
        int old_sec;
        if (!rs) begin
            m_mode = MIdle; m_prev = 0; m_remain = TurnCyc; m_sec = TurnS;
            m_tens = TurnS / 10; m_ones = TurnS % 10;
            m_tu = 0; m_warn = 0; m_run = 0;
            return;
        end
        old_sec = m_sec;
        m_tu = 0;
        if (st == 5) begin
            m_mode = MHalt;
        end else begin
            case (m_mode)
                MIdle: if (st == 1 && m_prev != 1) begin
                    m_mode = MRun; m_remain = TurnCyc; m_sec = TurnS;
                end
                MRun: if (st != 1) begin
                    m_mode = MIdle;
                end else if (!pa) begin
                    m_remain = m_remain - 1;
                    m_sec = (m_remain + ClkHz - 1) / ClkHz;
                    if (m_remain == 0) begin
                        m_tu = 1; m_mode = MExp;
                    end
                end
                MExp: if (st == 1) begin
                    m_mode = MRun; m_remain = TurnCyc; m_sec = TurnS;
                end else begin
                    m_mode = MIdle;
                end
                default: ;
            endcase
        end
        m_run  = (m_mode == MRun);
        m_warn = m_run && m_sec > 0 && m_sec <= WarnS;
        m_tens = old_sec / 10;
        m_ones = old_sec % 10;
        m_prev = st;
    endfunction

    function automatic logic [17:0] exp_vec();
        return {m_tu, 7'(m_sec), 4'(m_tens), 4'(m_ones), m_warn, m_run};
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, settle past it.
    task automatic cycle(input int st, input bit pa, input bit rs);
        state = 3'(st);
        pause = pa;
        reset = rs;
        @(posedge clk);
        model_step(st, pa, rs);
        #1;
    endtask

    task automatic test_reset();
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        checks++;
        if (obs !== {1'b0, 7'd3, 4'd0, 4'd3, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values got=%h want=%h", obs, {1'b0, 7'd3, 4'd0, 4'd3, 1'b0, 1'b0});
        end
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL idle_after_reset got=%h want=%h", obs, exp_vec());
            end
        end
    endtask

    task automatic test_normal_expiry();
        int run_k;
        int tu_k;
        int warn_cnt;
        run_k = -1; tu_k = -1; warn_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            cycle(1, 0, 1);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL normal_model k=%0d got=%h want=%h", k, obs, exp_vec());
            end
            if (running && run_k < 0) run_k = k;
            if (times_up && tu_k < 0) tu_k = k;
            if (warn) warn_cnt++;
        end
        checks++;
        if (run_k !== 0) begin
            errors++;
            $display("FAIL start_latency got=%0d want=0", run_k);
        end
        checks++;
        if (tu_k !== TurnCyc) begin
            errors++;
            $display("FAIL expiry_time got=%0d want=%0d", tu_k, TurnCyc);
        end
        checks++;
        if (warn_cnt !== ClkHz) begin
            errors++;
            $display("FAIL warn_cycles got=%0d want=%0d", warn_cnt, ClkHz);
        end
        cycle(2, 0, 1);
    endtask

    task automatic test_move_before_expiry();
        for (int k = 0; k < 6; k++) cycle(1, 0, 1);
        for (int k = 0; k < 5; k++) begin
            cycle(2, 0, 1);
            checks++;
            if (times_up !== 1'b0 || running !== 1'b0 || seconds_left !== 7'd2) begin
                errors++;
                $display("FAIL move_hold got tu=%b run=%b sec=%0d want tu=0 run=0 sec=2",
                         times_up, running, seconds_left);
            end
        end
        cycle(3, 0, 1);
        cycle(4, 0, 1);
        cycle(1, 0, 1);
        checks++;
        if (seconds_left !== 7'd3 || running !== 1'b1 || obs !== exp_vec()) begin
            errors++;
            $display("FAIL move_reload got=%h want=%h", obs, exp_vec());
        end
        cycle(2, 0, 1);
    endtask

    task automatic test_retry();
        int tu1;
        int tu2;
        tu1 = -1; tu2 = -1;
        cycle(2, 0, 1);
        for (int k = 0; k < 30; k++) begin
            cycle(1, 0, 1);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL retry_model k=%0d got=%h want=%h", k, obs, exp_vec());
            end
            if (times_up) begin
                if (tu1 < 0) tu1 = k;
                else if (tu2 < 0) tu2 = k;
            end
            if (k == TurnCyc + 1) begin
                checks++;
                if (seconds_left !== 7'd3 || running !== 1'b1) begin
                    errors++;
                    $display("FAIL retry_reload got sec=%0d run=%b want sec=3 run=1",
                             seconds_left, running);
                end
            end
        end
        checks++;
        if (tu1 !== TurnCyc || tu2 !== 2 * TurnCyc + 1) begin
            errors++;
            $display("FAIL retry_pulses got=%0d,%0d want=%0d,%0d", tu1, tu2, TurnCyc,
                     2 * TurnCyc + 1);
        end
        cycle(2, 0, 1);
    endtask

    task automatic test_pause();
        int tu_k;
        tu_k = -1;
        cycle(2, 0, 1);
        for (int k = 0; k < 30; k++) begin
            cycle(1, (k >= 5 && k < 15), 1);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL pause_model k=%0d got=%h want=%h", k, obs, exp_vec());
            end
            if (k >= 5 && k < 15 && seconds_left !== 7'd2) begin
                errors++;
                $display("FAIL pause_frozen k=%0d got=%0d want=2", k, seconds_left);
            end
            if (times_up && tu_k < 0) tu_k = k;
        end
        checks++;
        if (tu_k !== TurnCyc + 10) begin
            errors++;
            $display("FAIL pause_delay got=%0d want=%0d", tu_k, TurnCyc + 10);
        end
        cycle(2, 0, 1);
    endtask

    task automatic test_collision();
        int tu_seen;
        tu_seen = 0;
        cycle(2, 0, 1);
        for (int k = 0; k < 16; k++) begin
            cycle((k < TurnCyc) ? 1 : 2, 0, 1);
            if (times_up) tu_seen++;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL collide_model k=%0d got=%h want=%h", k, obs, exp_vec());
            end
        end
        checks++;
        if (tu_seen !== 0 || seconds_left !== 7'd1 || running !== 1'b0) begin
            errors++;
            $display("FAIL collide got tu=%0d sec=%0d run=%b want tu=0 sec=1 run=0",
                     tu_seen, seconds_left, running);
        end
    endtask

    task automatic test_halt();
        int st;
        cycle(2, 0, 1);
        for (int k = 0; k < 3; k++) cycle(1, 0, 1);
        cycle(5, 0, 1);
        checks++;
        if (running !== 1'b0 || warn !== 1'b0 || obs !== exp_vec()) begin
            errors++;
            $display("FAIL halt_enter got=%h want=%h", obs, exp_vec());
        end
        for (int k = 0; k < 40; k++) begin
            st = (k % 3 == 0) ? 1 : int'($urandom_range(0, 5));
            cycle(st, $urandom_range(0, 1) == 0, 1);
            checks++;
            if (times_up !== 1'b0 || running !== 1'b0 || seconds_left !== 7'd3) begin
                errors++;
                $display("FAIL halt_frozen k=%0d got tu=%b run=%b sec=%0d want tu=0 run=0 sec=3",
                         k, times_up, running, seconds_left);
            end
        end
    endtask

    task automatic test_reset_mid();
        cycle(0, 0, 0);
        cycle(2, 0, 1);
        for (int k = 0; k < 6; k++) cycle(1, 0, 1);
        cycle(1, 0, 0);
        checks++;
        if (obs !== {1'b0, 7'd3, 4'd0, 4'd3, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid got=%h want=%h", obs, {1'b0, 7'd3, 4'd0, 4'd3, 1'b0, 1'b0});
        end
        cycle(0, 0, 1);
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL reset_mid_release got=%h want=%h", obs, exp_vec());
        end
    endtask

    task automatic test_random();
        int st;
        int r;
        bit rs;
        bit pa;
        st = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                r = int'($urandom_range(0, 99));
                if (r < 50) st = 1;
                else if (r < 98) st = (r % 4 == 0) ? 0 : 2 + (r % 3);
                else st = 5;
            end
            rs = ($urandom_range(0, 199) != 0);
            pa = ($urandom_range(0, 9) == 0);
            cycle(st, pa, rs);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random k=%0d st=%0d pa=%b rs=%b got=%h want=%h",
                         k, st, pa, rs, obs, exp_vec());
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        state  = 3'd0;
        pause  = 1'b0;
        reset  = 1'b0;
        test_reset();
        test_normal_expiry();
        test_move_before_expiry();
        test_retry();
        test_pause();
        test_collision();
        test_halt();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
